lsu_dram_ctrl: RTL and testbench

- Load/store unit between the core's MEM stage and the word-wide data RAM (16-bit word address, 32-bit data, synchronous write, registered read with 1-cycle latency, read-before-write).
- Converts RV32I byte/halfword/word loads and stores into word accesses:
  - sign/zero extension on loads;
  - read-modify-write for SB/SH.
- Valid/ready request handshake toward the core; single-cycle response pulse.

---
 rtl/lsu_pkg.sv | 32 +++
 rtl/lsu_dram_ctrl_if.sv | 29 ++
 rtl/lsu_align.sv | 37 +++
 rtl/lsu_dram_ctrl.sv | 145 ++++++++++++++
 tb/tb_lsu_dram_ctrl.sv | 224 ++++++++++++++++++++++
 5 files changed

// File: rtl/lsu_pkg.sv
// Shared types for the load/store unit: funct3 encodings, FSM states, lane widths.
// Optional misaligned-access trapping is enabled by defining LSU_MISALIGN_CHECK_EN.
package lsu_pkg;

  typedef enum logic [2:0] {
    OP_B  = 3'b000,
    OP_H  = 3'b001,
    OP_W  = 3'b010,
    OP_BU = 3'b100,
    OP_HU = 3'b101
  } mem_op_e;

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    MERGE,
    DONE,
    ERR
  } lsu_state_e;

  localparam int BYTE_W = 8;
  localparam int HALF_W = 16;
  localparam int WORD_W = 32;

  // Unknown funct3 values fall back to word size, so they need full alignment.
  function automatic logic is_misaligned(logic we, logic [2:0] op, logic [1:0] off);
    if (op == OP_B || (!we && op == OP_BU)) return 1'b0;
    if (op == OP_H || (!we && op == OP_HU)) return off[0];
    return off != 2'b00;
  endfunction

endpackage

// File: rtl/lsu_dram_ctrl_if.sv
// Core request/response handshake plus data-RAM port of the load/store unit.
// The slave modport is the LSU; master is the core and RAM side.
interface lsu_dram_ctrl_if #(
  parameter int DRAM_AW = 16
);
  logic               req_valid;
  logic               req_ready;
  logic               req_we;
  logic [2:0]         req_op;
  logic [31:0]        req_addr;
  logic [31:0]        req_wdata;
  logic               resp_valid;
  logic [31:0]        resp_rdata;
  logic               resp_err;
  logic [DRAM_AW-1:0] dram_a;
  logic               dram_we;
  logic [31:0]        dram_din;
  logic [31:0]        dram_spo;

  modport slave (
    input  req_valid, req_we, req_op, req_addr, req_wdata, dram_spo,
    output req_ready, resp_valid, resp_rdata, resp_err, dram_a, dram_we, dram_din
  );

  modport master (
    output req_valid, req_we, req_op, req_addr, req_wdata, dram_spo,
    input  req_ready, resp_valid, resp_rdata, resp_err, dram_a, dram_we, dram_din
  );
endinterface

// File: rtl/lsu_align.sv
// Lane selection for the LSU: load extension from the RAM word and the
// byte/halfword merge used by the read-modify-write store path.
module lsu_align
  import lsu_pkg::*;
(
  input  logic [WORD_W-1:0] spo,
  input  logic [WORD_W-1:0] wdata,
  input  logic [1:0]        off,
  input  logic [2:0]        op,
  output logic [WORD_W-1:0] rdata,
  output logic [WORD_W-1:0] merged
);

  logic [BYTE_W-1:0] lane_b;
  logic [HALF_W-1:0] lane_h;

  always_comb begin
    lane_b = spo[{off, 3'b000} +: BYTE_W];
    lane_h = spo[{off[1], 4'b0000} +: HALF_W];

    case (op)
      OP_B:    rdata = {{(WORD_W-BYTE_W){lane_b[BYTE_W-1]}}, lane_b};
      OP_BU:   rdata = {{(WORD_W-BYTE_W){1'b0}}, lane_b};
      OP_H:    rdata = {{(WORD_W-HALF_W){lane_h[HALF_W-1]}}, lane_h};
      OP_HU:   rdata = {{(WORD_W-HALF_W){1'b0}}, lane_h};
      default: rdata = spo;
    endcase

    merged = spo;
    case (op)
      OP_B:    merged[{off, 3'b000} +: BYTE_W]    = wdata[BYTE_W-1:0];
      OP_H:    merged[{off[1], 4'b0000} +: HALF_W] = wdata[HALF_W-1:0];
      default: merged = wdata;
    endcase
  end

endmodule

// File: rtl/lsu_dram_ctrl.sv
// Load/store unit between the MEM stage and a word-wide registered-read data RAM.
// Define LSU_MISALIGN_CHECK_EN to trap misaligned accesses instead of aligning down.
module lsu_dram_ctrl
  import lsu_pkg::*;
#(
  parameter int DRAM_AW = 16
) (
  input  logic           clk,
  input  logic           rst,
  lsu_dram_ctrl_if.slave bus
);

  lsu_state_e         state_q, state_d;
  logic [DRAM_AW-1:0] waddr_q, waddr_d;
  logic [1:0]         off_q, off_d;
  logic [2:0]         op_q, op_d;
  logic [31:0]        wdata_q, wdata_d;

  logic [DRAM_AW-1:0] req_word;
  logic               unused_addr_hi;
  logic               sub_word;
  logic [31:0]        ld_data, mg_data;

  logic               ready_c, rv_c, we_c;
  logic [31:0]        rdata_c, din_c;
  logic [DRAM_AW-1:0] a_c;

  assign req_word       = bus.req_addr[DRAM_AW+1:2];
  assign unused_addr_hi = ^bus.req_addr[31:DRAM_AW+2];
  assign sub_word       = bus.req_op == OP_B || bus.req_op == OP_H;

`ifdef LSU_MISALIGN_CHECK_EN
  logic misalign;
  logic err_c;
  assign misalign = is_misaligned(bus.req_we, bus.req_op, bus.req_addr[1:0]);
`endif

  lsu_align u_align (
    .spo    (bus.dram_spo),
    .wdata  (wdata_q),
    .off    (off_q),
    .op     (op_q),
    .rdata  (ld_data),
    .merged (mg_data)
  );

  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
    waddr_q <= waddr_d;
    off_q   <= off_d;
    op_q    <= op_d;
    wdata_q <= wdata_d;
  end

  always_comb begin
    state_d = state_q;
    waddr_d = waddr_q;
    off_d   = off_q;
    op_d    = op_q;
    wdata_d = wdata_q;
    ready_c = 1'b0;
    rv_c    = 1'b0;
    rdata_c = '0;
    we_c    = 1'b0;
    din_c   = '0;
    a_c     = waddr_q;
`ifdef LSU_MISALIGN_CHECK_EN
    err_c   = 1'b0;
`endif

    case (state_q)
      IDLE: begin
        a_c     = req_word;
        ready_c = 1'b1;
        if (bus.req_valid) begin
          waddr_d = req_word;
          off_d   = bus.req_addr[1:0];
          op_d    = bus.req_op;
          wdata_d = bus.req_wdata;
`ifdef LSU_MISALIGN_CHECK_EN
          if (misalign) state_d = ERR;
          else
`endif
          if (!bus.req_we) state_d = LOAD;
          else if (sub_word) state_d = MERGE;
          else begin
            // Full-word store writes straight through in the accept cycle.
            we_c    = 1'b1;
            din_c   = bus.req_wdata;
            state_d = DONE;
          end
        end
      end
      LOAD: begin
        rv_c    = 1'b1;
        rdata_c = ld_data;
        state_d = IDLE;
      end
      MERGE: begin
        // dram_spo holds the word read during the accept cycle.
        we_c    = 1'b1;
        din_c   = mg_data;
        state_d = DONE;
      end
      DONE: begin
        rv_c    = 1'b1;
        state_d = IDLE;
      end
`ifdef LSU_MISALIGN_CHECK_EN
      ERR: begin
        rv_c    = 1'b1;
        err_c   = 1'b1;
        state_d = IDLE;
      end
`endif
      default: state_d = IDLE;
    endcase

    if (rst) begin
      ready_c = 1'b0;
      rv_c    = 1'b0;
      rdata_c = '0;
      we_c    = 1'b0;
      din_c   = '0;
      a_c     = '0;
`ifdef LSU_MISALIGN_CHECK_EN
      err_c   = 1'b0;
`endif
    end
  end

  assign bus.req_ready  = ready_c;
  assign bus.resp_valid = rv_c;
  assign bus.resp_rdata = rdata_c;
  assign bus.dram_a     = a_c;
  assign bus.dram_we    = we_c;
  assign bus.dram_din   = din_c;
`ifdef LSU_MISALIGN_CHECK_EN
  assign bus.resp_err   = err_c;
`else
  assign bus.resp_err   = 1'b0;
`endif

endmodule

// File: tb/tb_lsu_dram_ctrl.sv
// Scoreboard bench for lsu_dram_ctrl: byte-addressed reference memory, RAM model,
// directed scenarios followed by randomized loads/stores.
module tb_lsu_dram_ctrl;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  lsu_dram_ctrl_if #(.DRAM_AW(16)) bus ();
  lsu_dram_ctrl #(.DRAM_AW(16)) dut (.clk(clk), .rst(rst), .bus(bus));

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic        init_req = 1'b0;
  logic [31:0] mem  [0:127];
  logic [7:0]  refm [0:511];

  function automatic logic [31:0] seed_word(int i);
    logic [31:0] w;
    w = 32'(i);
    return (w * 32'h9E3779B1) ^ 32'h5A5A1234;
  endfunction

  // Data RAM: registered read, read-before-write.
  always @(posedge clk) begin
    if (init_req) begin
      for (int i = 0; i < 128; i++) mem[i] <= seed_word(i);
    end else begin
      bus.dram_spo <= mem[bus.dram_a[6:0]];
      if (bus.dram_we) mem[bus.dram_a[6:0]] <= bus.dram_din;
    end
  end

  typedef struct {
    logic [31:0] rdata;
    logic        err;
    int          due;
  } exp_t;
  exp_t expq[$];
  exp_t mon_e;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  always @(negedge clk) begin
    if (!rst && bus.resp_valid) begin
      if (expq.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_resp: resp_valid with no pending request (cycle %0d)", cyc);
      end else begin
        mon_e = expq.pop_front();
        chk("resp_rdata", bus.resp_rdata, mon_e.rdata);
        chk("resp_err", 32'(bus.resp_err), 32'(mon_e.err));
        chk("resp_cycle", 32'(cyc), 32'(mon_e.due));
      end
    end
  end

  function automatic int acc_size(bit we, bit [2:0] op);
    if (op == 3'b000 || (!we && op == 3'b100)) return 1;
    if (op == 3'b001 || (!we && op == 3'b101)) return 2;
    return 4;
  endfunction

  task automatic issue(input bit we, input bit [2:0] op, input bit [31:0] addr,
                       input bit [31:0] wdata, input bit use_lit, input bit [31:0] lit,
                       input bit rst_merge);
    int          sz, ba, wb, k, waits;
    bit          mis, subw, sw;
    bit [31:0]   val, word;
    exp_t        e;
    sz  = acc_size(we, op);
    mis = 1'b0;
`ifdef LSU_MISALIGN_CHECK_EN
    mis = (addr % sz) != 0;
`endif
    ba  = int'(addr[8:0]) & ~(sz - 1);
    val = '0;
    if (!mis && !we) begin
      for (int i = 0; i < sz; i++) val |= 32'(refm[ba + i]) << (8 * i);
      if ((op == 3'b000 || op == 3'b001) && sz < 4 && val[8*sz-1])
        val |= 32'hFFFFFFFF << (8 * sz);
    end
    subw = we && !mis && sz < 4;
    sw   = we && !mis && sz == 4;

    bus.req_valid = 1'b1;
    bus.req_we    = we;
    bus.req_op    = op;
    bus.req_addr  = addr;
    bus.req_wdata = wdata;
    waits = 0;
    #2;
    while (!bus.req_ready && waits < 20) begin
      @(negedge clk);
      #2;
      waits++;
    end
    if (!bus.req_ready) begin
      checks++;
      errors++;
      $display("FAIL accept_timeout: req_ready low for %0d cycles", waits);
      bus.req_valid = 1'b0;
      return;
    end
    k = cyc;
    chk("acc_dram_a", 32'(bus.dram_a), 32'(addr[17:2]));
    chk("acc_dram_we", 32'(bus.dram_we), 32'(sw));
    if (sw) chk("acc_dram_din", bus.dram_din, wdata);

    if (!rst_merge) begin
      if (we && !mis)
        for (int i = 0; i < sz; i++) refm[ba + i] = 8'(wdata >> (8 * i));
      e.rdata = use_lit ? lit : val;
      e.err   = mis;
      e.due   = k + (subw ? 2 : 1);
      expq.push_back(e);
    end
    wb   = ba & ~3;
    word = {refm[wb+3], refm[wb+2], refm[wb+1], refm[wb]};

    @(posedge clk);
    #1;
    bus.req_valid = 1'b0;
    if (rst_merge) rst = 1'b1;
    @(negedge clk);
    if (rst_merge) begin
      chk("rst_merge_we", 32'(bus.dram_we), 32'd0);
      chk("rst_merge_resp", 32'(bus.resp_valid), 32'd0);
      @(posedge clk);
      #1;
      rst = 1'b0;
      @(negedge clk);
      chk("rst_ready", 32'(bus.req_ready), 32'd1);
    end else if (subw) begin
      chk("merge_we", 32'(bus.dram_we), 32'd1);
      chk("merge_din", bus.dram_din, word);
    end else begin
      chk("post_we", 32'(bus.dram_we), 32'd0);
    end
  endtask

  bit [2:0] op_tab [10] = '{3'd0, 3'd1, 3'd2, 3'd4, 3'd5, 3'd0, 3'd1, 3'd2, 3'd3, 3'd7};

  initial begin
    int          drain;
    bit [31:0]   raddr;
    bus.req_valid = 1'b1;
    bus.req_we    = 1'b1;
    bus.req_op    = 3'b010;
    bus.req_addr  = 32'h1234_5677;
    bus.req_wdata = 32'hFFFF_FFFF;
    init_req      = 1'b1;
    for (int i = 0; i < 512; i++) refm[i] = 8'(seed_word(i / 4) >> (8 * (i % 4)));
    repeat (2) @(posedge clk);
    #1 init_req = 1'b0;

    @(negedge clk);
    chk("rst_req_ready", 32'(bus.req_ready), 32'd0);
    chk("rst_resp_valid", 32'(bus.resp_valid), 32'd0);
    chk("rst_resp_err", 32'(bus.resp_err), 32'd0);
    chk("rst_resp_rdata", bus.resp_rdata, 32'd0);
    chk("rst_dram_we", 32'(bus.dram_we), 32'd0);
    chk("rst_dram_a", 32'(bus.dram_a), 32'd0);
    chk("rst_dram_din", bus.dram_din, 32'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    bus.req_valid = 1'b0;
    @(negedge clk);

    issue(1'b1, 3'b010, 32'h100, 32'hDEADBEEF, 1'b0, 32'h0, 1'b0);
    issue(1'b0, 3'b000, 32'h103, 32'h0, 1'b1, 32'hFFFFFFDE, 1'b0);
    issue(1'b0, 3'b100, 32'h103, 32'h0, 1'b1, 32'h000000DE, 1'b0);
    issue(1'b0, 3'b000, 32'h100, 32'h0, 1'b1, 32'hFFFFFFEF, 1'b0);
    issue(1'b1, 3'b000, 32'h101, 32'h12345655, 1'b0, 32'h0, 1'b0);
    issue(1'b0, 3'b010, 32'h100, 32'h0, 1'b1, 32'hDEAD55EF, 1'b0);
    issue(1'b0, 3'b001, 32'h102, 32'h0, 1'b1, 32'hFFFFDEAD, 1'b0);
    issue(1'b0, 3'b101, 32'h102, 32'h0, 1'b1, 32'h0000DEAD, 1'b0);
    issue(1'b1, 3'b001, 32'h102, 32'h00000BEE, 1'b0, 32'h0, 1'b0);
    issue(1'b0, 3'b010, 32'h100, 32'h0, 1'b1, 32'h0BEE55EF, 1'b0);
`ifdef LSU_MISALIGN_CHECK_EN
    issue(1'b0, 3'b010, 32'h101, 32'h0, 1'b1, 32'h00000000, 1'b0);
`else
    issue(1'b0, 3'b010, 32'h101, 32'h0, 1'b1, 32'h0BEE55EF, 1'b0);
`endif
    issue(1'b1, 3'b001, 32'h100, 32'h0000AAAA, 1'b0, 32'h0, 1'b1);
    issue(1'b0, 3'b010, 32'h100, 32'h0, 1'b1, 32'h0BEE55EF, 1'b0);

    for (int n = 0; n < 300; n++) begin
      raddr = ($urandom & 32'hFFFC_0000) | 32'($urandom_range(0, 511));
      issue(1'($urandom_range(0, 1)), op_tab[$urandom_range(0, 9)], raddr, $urandom,
            1'b0, 32'h0, 1'b0);
      if ($urandom_range(0, 3) == 0) repeat ($urandom_range(1, 3)) @(negedge clk);
    end

    drain = 0;
    while (expq.size() != 0 && drain < 10) begin
      @(negedge clk);
      drain++;
    end
    if (expq.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL drain: %0d responses never arrived", expq.size());
    end
    repeat (2) @(negedge clk);
    for (int w = 0; w < 128; w++)
      chk("mem_word", mem[w], {refm[4*w+3], refm[4*w+2], refm[4*w+1], refm[4*w]});

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
